pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central hazard and memory-sequencing controller for the 5-stage CPU pipeline. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their hold/flush controls. Detects load-use hazards, flushes on taken jumps, selects operand forwarding sources, and sequences multi-cycle data-memory accesses through a req/ack handshake with a timeout. Maintains a saturating stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEM_WAIT before declaring a memory error (1..65535).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_r2, id_r3  in  4  source register indices of the instruction in ID.
- id_use_r2, id_use_r3  in  1  the ID instruction actually reads that source.
- ex_dest  in  4, ex_wreg  in  1, ex_rmem  in  1  destination, register-write and load flags of the instruction in EX.
- ex_wpc  in  1  instruction in EX is a taken jump (writes PC).
- mem_dest  in  4, mem_wreg, mem_rmem, mem_wmem  in  1  fields of the instruction in MEM.
- wb_dest  in  4, wb_wreg  in  1  fields of the instruction in WB.
- dmem_ack  in  1  data memory completes the current access.
- dmem_req  out  1  request to data memory.
- dmem_we  out  1  request is a write (equals mem_wmem while dmem_req).
- stall_if, stall_id  out  1  hold PC and IF/ID register.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id, flush_id_ex  out  1  clear those pipeline registers.
- stall_all  out  1  freeze every pipeline register and PC.
- fwd_r2, fwd_r3  out  2  operand source for EX: 00 register file, 01 MEM-stage result, 10 WB result.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  saturating count of cycles with any stall/bubble/stall_all asserted.

## Operation
- All 16 registers are ordinary; index 0 gets no special treatment.
- FSM states: IDLE, MEM_WAIT, ERR.
  - IDLE: if mem_rmem|mem_wmem, dmem_req=1 combinationally. If dmem_ack in the same cycle, access is done and no stall occurs. Otherwise stall_all=1 and the next state is MEM_WAIT; timeout counter loads 1.
  - MEM_WAIT: dmem_req=1, stall_all=1. On dmem_ack: stall_all=0 that cycle, next state IDLE. If the counter reaches MEM_TIMEOUT without ack: next state ERR. Otherwise the counter increments.
  - ERR: dmem_req=0, stall_all=1, mem_err=1. Only rst leaves this state.
- Load-use: ex_rmem & ex_wreg & ((id_use_r2 & id_r2==ex_dest) | (id_use_r3 & id_r3==ex_dest)) drives stall_if=stall_id=bubble_ex=1.
- Jump: ex_wpc drives flush_if_id=flush_id_ex=1 and suppresses load-use outputs in the same cycle.
- stall_all has top priority. While it is asserted, stall_if, stall_id, bubble_ex and both flushes are 0. The frozen EX re-evaluates after release.
- Forwarding, per operand:
  - MEM match with mem_wreg & !mem_rmem gives 01.
  - Otherwise a WB match with wb_wreg gives 10.
  - Otherwise 00.
  - MEM has priority over WB. Forwarding outputs are valid regardless of stalls.
- stall_cnt increments by 1 in any cycle where stall_if|bubble_ex|stall_all. It holds at all-ones.

## Timing
- Reset values: state IDLE, timeout counter 0, mem_err 0, stall_cnt 0. All combinational outputs evaluate from inputs with state IDLE.
- Hazard, flush and forwarding outputs are combinational from the current-cycle inputs, with zero latency.
- Single-cycle memory (ack in the request cycle) adds 0 stall cycles. An ack N cycles after the request adds N stall cycles.
- Timeout boundary: ack arriving in the same cycle the counter equals MEM_TIMEOUT wins; the state goes to IDLE, not ERR.
- rst asserted mid-MEM_WAIT aborts the access: dmem_req drops immediately (asynchronous) and the counter clears.
- mem_err and stall_cnt are registered and update one edge after the qualifying cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (IDLE, MEM_WAIT, ERR);
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - a register-index width constant of 4.
- Sub-module pipe_fwd_unit: a combinational forwarding selector for one operand, instantiated twice (r2, r3).
- FSM, timeout counter and stall counter live in the top block.

## Test plan
- Load-use: ex_rmem=1, ex_wreg=1, ex_dest=5, id_r2=5, id_use_r2=1 -> stall_if=stall_id=bubble_ex=1. Same with id_use_r2=0 -> all 0.
- Jump plus load-use together: ex_wpc=1 with the load-use condition above -> flush_if_id=flush_id_ex=1, bubble_ex=0, stall_if=0.
- Forwarding priority: mem_dest=3, mem_wreg=1, mem_rmem=0, wb_dest=3, wb_wreg=1, id_r3=3 -> fwd_r3=01. Set mem_rmem=1 -> fwd_r3=10.
- Wait-state access: mem_rmem=1, ack 3 cycles after the request -> stall_all high exactly 3 cycles, dmem_req high 4 cycles, stall_cnt=3, state returns to IDLE.
- Timeout: MEM_TIMEOUT=4, mem_wmem=1, no ack -> ERR after 4 wait cycles; mem_err=1, dmem_req=0, stall_all=1 held until rst.
- Reset in MEM_WAIT: rst pulse after 2 wait cycles -> dmem_req=0 immediately, stall_cnt=0, mem_err=0, no error.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / memory-sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    ERR
  } state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-stage fields in, hold/flush/forward/memory controls out.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic [REG_W-1:0] id_r2, id_r3;
  logic             id_use_r2, id_use_r3;
  logic [REG_W-1:0] ex_dest;
  logic             ex_wreg, ex_rmem, ex_wpc;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wreg, mem_rmem, mem_wmem;
  logic [REG_W-1:0] wb_dest;
  logic             wb_wreg;
  logic             dmem_ack;

  logic             dmem_req, dmem_we;
  logic             stall_if, stall_id, bubble_ex;
  logic             flush_if_id, flush_id_ex;
  logic             stall_all;
  fwd_sel_t         fwd_r2, fwd_r3;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_r2, id_r3, id_use_r2, id_use_r3, ex_dest, ex_wreg, ex_rmem, ex_wpc,
           mem_dest, mem_wreg, mem_rmem, mem_wmem, wb_dest, wb_wreg, dmem_ack,
    input  dmem_req, dmem_we, stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex,
           stall_all, fwd_r2, fwd_r3, mem_err, stall_cnt
  );

  modport slave (
    input  id_r2, id_r3, id_use_r2, id_use_r3, ex_dest, ex_wreg, ex_rmem, ex_wpc,
           mem_dest, mem_wreg, mem_rmem, mem_wmem, wb_dest, wb_wreg, dmem_ack,
    output dmem_req, dmem_we, stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex,
           stall_all, fwd_r2, fwd_r3, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Operand forwarding selector for one EX source; MEM result beats WB result.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_wreg_i,
  input  logic             mem_rmem_i,
  input  logic [REG_W-1:0] wb_dest_i,
  input  logic             wb_wreg_i,
  output fwd_sel_t         fwd_o
);

  // A load in MEM has no data yet, so it cannot forward from that stage.
  always_comb begin
    fwd_o = FWD_RF;
    if (mem_wreg_i && !mem_rmem_i && (src_i == mem_dest_i)) begin
      fwd_o = FWD_MEM;
    end else if (wb_wreg_i && (src_i == wb_dest_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, jump flush, forwarding and data-memory wait/timeout sequencing.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q;
  logic [TW-1:0]    tmo_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_acc, dmem_req, stall_all, load_use, lu_act, flush, stall_any;

  assign mem_acc = bus.mem_rmem | bus.mem_wmem;

  always_comb begin
    dmem_req  = 1'b0;
    stall_all = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem_req  = mem_acc;
        stall_all = mem_acc & ~bus.dmem_ack;
      end
      MEM_WAIT: begin
        dmem_req  = 1'b1;
        stall_all = ~bus.dmem_ack;
      end
      ERR:     stall_all = 1'b1;
      default: ;
    endcase
  end

  assign load_use = bus.ex_rmem & bus.ex_wreg &
                    ((bus.id_use_r2 & (bus.id_r2 == bus.ex_dest)) |
                     (bus.id_use_r3 & (bus.id_r3 == bus.ex_dest)));

  // stall_all freezes everything, so the held EX instruction is re-judged on release.
  assign lu_act = load_use & ~bus.ex_wpc & ~stall_all;
  assign flush  = bus.ex_wpc & ~stall_all;

  assign bus.dmem_req    = dmem_req;
  assign bus.dmem_we     = dmem_req & bus.mem_wmem;
  assign bus.stall_all   = stall_all;
  assign bus.stall_if    = lu_act;
  assign bus.stall_id    = lu_act;
  assign bus.bubble_ex   = lu_act;
  assign bus.flush_if_id = flush;
  assign bus.flush_id_ex = flush;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_cnt   = cnt_q;

  pipe_fwd_unit u_fwd_r2 (
    .src_i      (bus.id_r2),
    .mem_dest_i (bus.mem_dest),
    .mem_wreg_i (bus.mem_wreg),
    .mem_rmem_i (bus.mem_rmem),
    .wb_dest_i  (bus.wb_dest),
    .wb_wreg_i  (bus.wb_wreg),
    .fwd_o      (bus.fwd_r2)
  );

  pipe_fwd_unit u_fwd_r3 (
    .src_i      (bus.id_r3),
    .mem_dest_i (bus.mem_dest),
    .mem_wreg_i (bus.mem_wreg),
    .mem_rmem_i (bus.mem_rmem),
    .wb_dest_i  (bus.wb_dest),
    .wb_wreg_i  (bus.wb_wreg),
    .fwd_o      (bus.fwd_r3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_acc && !bus.dmem_ack) begin
            state_q <= MEM_WAIT;
            tmo_q   <= TW'(1);
          end
        end
        MEM_WAIT: begin
          // Ack on the limit cycle still completes the access.
          if (bus.dmem_ack) begin
            state_q <= IDLE;
            tmo_q   <= '0;
          end else if (tmo_q == TW'(MEM_TIMEOUT)) begin
            state_q   <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ERR:     mem_err_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_any = lu_act | stall_all;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_any && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] id_r2, id_r3;
    logic       id_use_r2, id_use_r3;
    logic [3:0] ex_dest;
    logic       ex_wreg, ex_rmem, ex_wpc;
    logic [3:0] mem_dest;
    logic       mem_wreg, mem_rmem, mem_wmem;
    logic [3:0] wb_dest;
    logic       wb_wreg, dmem_ack;
  } in_t;

  typedef struct packed {
    logic       dmem_req, dmem_we, stall_if, stall_id, bubble_ex;
    logic       flush_if_id, flush_id_ex, stall_all;
    logic [1:0] fwd_r2, fwd_r3;
    logic       mem_err;
  } outs_t;

  typedef struct {
    string       name;
    outs_t       exp;
    logic [15:0] cnt;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  exp_t  sb[$];
  exp_t  cur;
  outs_t got;
  int    n_vec = 0;
  int    n_bad = 0;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t o(input bit req, we, sif, sid, bub, fif, fex, sall,
                              input logic [1:0] f2, f3, input bit err);
    outs_t r;
    r.dmem_req = req;  r.dmem_we = we;  r.stall_if = sif;  r.stall_id = sid;
    r.bubble_ex = bub; r.flush_if_id = fif; r.flush_id_ex = fex; r.stall_all = sall;
    r.fwd_r2 = f2;     r.fwd_r3 = f3;   r.mem_err = err;
    return r;
  endfunction

  task automatic drive(input in_t v);
    bus.id_r2 = v.id_r2;       bus.id_r3 = v.id_r3;
    bus.id_use_r2 = v.id_use_r2; bus.id_use_r3 = v.id_use_r3;
    bus.ex_dest = v.ex_dest;   bus.ex_wreg = v.ex_wreg;
    bus.ex_rmem = v.ex_rmem;   bus.ex_wpc = v.ex_wpc;
    bus.mem_dest = v.mem_dest; bus.mem_wreg = v.mem_wreg;
    bus.mem_rmem = v.mem_rmem; bus.mem_wmem = v.mem_wmem;
    bus.wb_dest = v.wb_dest;   bus.wb_wreg = v.wb_wreg;
    bus.dmem_ack = v.dmem_ack;
  endtask

  task automatic apply(input string name, input bit r, input in_t v, input outs_t e,
                       input int cnt);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    drive(v);
    x.name = name;
    x.exp  = e;
    x.cnt  = 16'(cnt);
    sb.push_back(x);
  endtask

  // Monitor: one expected entry per cycle, checked mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        got = {bus.dmem_req, bus.dmem_we, bus.stall_if, bus.stall_id, bus.bubble_ex,
               bus.flush_if_id, bus.flush_id_ex, bus.stall_all, bus.fwd_r2, bus.fwd_r3,
               bus.mem_err};
        n_vec++;
        if (got !== cur.exp) begin
          n_bad++;
          $display("FAIL %s outputs got=%b expected=%b", cur.name, got, cur.exp);
        end
        n_vec++;
        if (bus.stall_cnt !== cur.cnt) begin
          n_bad++;
          $display("FAIL %s stall_cnt got=%0d expected=%0d", cur.name, bus.stall_cnt, cur.cnt);
        end
      end
    end
  end

  initial begin
    in_t   z, lu, v;
    outs_t zo, ws, wsw, er;
    z  = '0;
    lu = '0;
    lu.ex_rmem = 1'b1; lu.ex_wreg = 1'b1; lu.ex_dest = 4'd5;
    lu.id_r2 = 4'd5;   lu.id_use_r2 = 1'b1;
    zo  = o(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    ws  = o(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    wsw = o(1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0);
    er  = o(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1);
    drive(z);

    apply("reset", 1, z, zo, 0);
    apply("idle", 0, z, zo, 0);
    apply("load_use", 0, lu, o(0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0), 0);
    v = lu; v.id_use_r2 = 1'b0;
    apply("no_use", 0, v, zo, 1);
    v = z; v.ex_rmem = 1'b1; v.ex_wreg = 1'b1; v.ex_dest = 4'd5;
    v.id_r2 = 4'd5; v.id_r3 = 4'd5; v.id_use_r3 = 1'b1;
    apply("load_use_r3", 0, v, o(0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0), 1);
    v = lu; v.ex_wpc = 1'b1;
    apply("jump_lu", 0, v, o(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0), 2);

    v = z; v.mem_dest = 4'd3; v.mem_wreg = 1'b1; v.wb_dest = 4'd3; v.wb_wreg = 1'b1;
    v.id_r3 = 4'd3;
    apply("fwd_mem", 0, v, o(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0), 2);
    v.mem_rmem = 1'b1; v.dmem_ack = 1'b1;
    apply("fwd_wb_single_cyc", 0, v, o(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0), 2);
    v = z; v.id_r2 = 4'd3; v.id_r3 = 4'd7; v.mem_dest = 4'd3; v.mem_wreg = 1'b1;
    v.wb_dest = 4'd7; v.wb_wreg = 1'b1;
    apply("fwd_split", 0, v, o(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0), 2);
    v = z; v.id_r2 = 4'd9; v.id_r3 = 4'd0; v.mem_dest = 4'd0; v.mem_wreg = 1'b1;
    v.wb_dest = 4'd9; v.wb_wreg = 1'b1;
    apply("fwd_reg0", 0, v, o(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0), 2);

    v = lu; v.mem_rmem = 1'b1;
    apply("ws_req", 0, v, ws, 2);
    v.ex_wpc = 1'b1;
    apply("ws_wait1", 0, v, ws, 3);
    apply("ws_wait2", 0, v, ws, 4);
    v = z; v.mem_rmem = 1'b1; v.dmem_ack = 1'b1;
    apply("ws_ack", 0, v, o(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 5);
    apply("ws_idle", 0, z, zo, 5);

    v = z; v.mem_wmem = 1'b1;
    apply("bd_req", 0, v, wsw, 5);
    for (int i = 0; i < 3; i++) apply("bd_wait", 0, v, wsw, 6 + i);
    v.dmem_ack = 1'b1;
    apply("bd_ack_at_limit", 0, v, o(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 9);
    apply("bd_idle", 0, z, zo, 9);

    v = z; v.mem_wmem = 1'b1;
    apply("to_req", 0, v, wsw, 9);
    for (int i = 0; i < 4; i++) apply("to_wait", 0, v, wsw, 10 + i);
    v = lu; v.ex_wpc = 1'b1; v.mem_wmem = 1'b1;
    apply("err_entry", 0, v, er, 14);
    v.dmem_ack = 1'b1;
    apply("err_ack_ignored", 0, v, er, 15);
    apply("err_hold", 0, z, er, 16);

    apply("rst_err", 1, z, zo, 0);
    v = z; v.mem_rmem = 1'b1;
    apply("rw_req", 0, v, ws, 0);
    apply("rw_wait1", 0, v, ws, 1);
    apply("rw_wait2", 0, v, ws, 2);
    apply("rst_midwait", 1, z, zo, 0);
    apply("rst_release", 0, z, zo, 0);
    v = z; v.mem_rmem = 1'b1; v.dmem_ack = 1'b1;
    apply("post_rst_single", 0, v, o(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 0);

    repeat (3) @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
